// File: rtl/alu_ext_pkg.sv
// Shared definitions for the sequential extended ALU: operation codes,
// controller states, the divide-by-zero fill value and func decode helpers.
package alu_ext_pkg;

    typedef enum logic [2:0] {
        FUNC_MUL   = 3'b000,
        FUNC_UMUL  = 3'b001,
        FUNC_MULH  = 3'b010,
        FUNC_MULHU = 3'b011,
        FUNC_DIV   = 3'b100,
        FUNC_UDIV  = 3'b101,
        FUNC_REM   = 3'b110,
        FUNC_UREM  = 3'b111
    } func_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Quotient returned for a zero divisor is this bit replicated to WIDTH.
    localparam logic DZ_FILL = 1'b1;

    // func[2] selects the divider, func[0] marks unsigned operation and
    // func[1] picks the upper product half or the remainder.
    function automatic logic func_is_div(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic func_is_signed(input logic [2:0] f);
        return ~f[0];
    endfunction

    function automatic logic func_is_upper(input logic [2:0] f);
        return f[1];
    endfunction

endpackage

// File: rtl/alu_ext_seq_if.sv
// Request/result handshake bundle between the issuing pipeline (master)
// and the sequential extended ALU (slave).
interface alu_ext_seq_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       func;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src0;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dst;
    logic [TAG_W-1:0] out_tag;
    logic             ov;
    logic             zr;
    logic             neg;
    logic             dz;

    modport master (
        output in_valid, func, src1, src0, in_tag, out_ready,
        input  in_ready, out_valid, dst, out_tag, ov, zr, neg, dz
    );

    modport slave (
        input  in_valid, func, src1, src0, in_tag, out_ready,
        output in_ready, out_valid, dst, out_tag, ov, zr, neg, dz
    );
endinterface

// File: rtl/alu_ext_seq_abs_neg.sv
// Conditional two's-complement negate: y = en ? -a : a. Used both to take
// operand magnitudes and to restore the sign of the final result.
module abs_neg #(
    parameter int N = 32
) (
    input  logic         en,
    input  logic [N-1:0] a,
    output logic [N-1:0] y
);
    assign y = en ? (~a + 1'b1) : a;
endmodule

// File: rtl/alu_ext_seq.sv
// Multi-cycle extended ALU: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, one step per clock, with a one-clock fast path for
// divide-by-zero and signed MIN / -1.
module alu_ext_seq
    import alu_ext_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_ext_seq_if.slave bus
);
    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] DZ_RESULT = {WIDTH{DZ_FILL}};

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2:0]         func_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic               sa_reg, sb_reg;
    // m: multiplicand or divisor; hi/lo: product halves or remainder/quotient
    logic [WIDTH-1:0]   m_reg, hi_reg, lo_reg;
    logic [WIDTH-1:0]   dst_reg;
    logic [TAG_W-1:0]   out_tag_reg;
    logic               ov_reg, zr_reg, neg_reg, dz_reg;

    logic               in_ready, accept;
    logic               in_div, in_signed, in_upper, in_sa, in_sb;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               div_zero, div_ovf, fast;
    logic [WIDTH-1:0]   fast_dst;

    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic               div_ok;
    logic [WIDTH-1:0]   step_hi, step_lo;

    logic               f_div, f_signed, f_upper, fix_en;
    logic [2*WIDTH-1:0] fix_in, fixed;
    logic [WIDTH-1:0]   fin_dst;
    logic               fin_ov;

    assign in_ready = (state_reg == IDLE) | ((state_reg == DONE) & bus.out_ready);
    assign accept   = bus.in_valid & in_ready;

    // Request decode and operand magnitudes, evaluated on the live inputs
    assign in_div    = func_is_div(bus.func);
    assign in_signed = func_is_signed(bus.func);
    assign in_upper  = func_is_upper(bus.func);
    assign in_sa     = in_signed & bus.src1[WIDTH-1];
    assign in_sb     = in_signed & bus.src0[WIDTH-1];

    abs_neg #(.N(WIDTH)) u_abs_a (.en(in_sa), .a(bus.src1), .y(a_mag));
    abs_neg #(.N(WIDTH)) u_abs_b (.en(in_sb), .a(bus.src0), .y(b_mag));

    // Special divide cases bypass the iterative datapath entirely
    assign div_zero = in_div & (bus.src0 == '0);
    assign div_ovf  = in_div & in_signed & (bus.src1 == MIN_VAL) & (bus.src0 == '1);
    assign fast     = div_zero | div_ovf;
    assign fast_dst = div_zero ? (in_upper ? bus.src1 : DZ_RESULT)
                               : (in_upper ? '0 : MIN_VAL);

    // One shift-add multiply step: add multiplicand if multiplier LSB set, shift right
    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, m_reg} : '0);
    // One restoring divide step: shift in next dividend bit, subtract if it fits
    assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, m_reg};
    assign div_ok    = ~div_trial[WIDTH];

    assign f_div    = func_is_div(func_reg);
    assign f_signed = func_is_signed(func_reg);
    assign f_upper  = func_is_upper(func_reg);

    assign step_hi = f_div ? (div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0])
                           : mul_sum[WIDTH:1];
    assign step_lo = f_div ? {lo_reg[WIDTH-2:0], div_ok}
                           : {mul_sum[0], lo_reg[WIDTH-1:1]};

    // Sign correction of the value produced by the final step; remainder
    // follows the dividend sign, everything else the xor of operand signs.
    assign fix_in = f_div ? {{WIDTH{1'b0}}, (f_upper ? step_hi : step_lo)}
                          : {step_hi, step_lo};
    assign fix_en = f_signed & ((f_div & f_upper) ? sa_reg : (sa_reg ^ sb_reg));

    abs_neg #(.N(2*WIDTH)) u_fix (.en(fix_en), .a(fix_in), .y(fixed));

    assign fin_dst = (~f_div & f_upper) ? fixed[2*WIDTH-1:WIDTH] : fixed[WIDTH-1:0];
    assign fin_ov  = ~f_div & ~f_upper &
                     (f_signed ? (fixed[2*WIDTH-1:WIDTH] != {WIDTH{fixed[WIDTH-1]}})
                               : (|fixed[2*WIDTH-1:WIDTH]));

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state selection; a result hand-off may accept the next request
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = fast ? DONE : CALC;
            CALC: if (cnt_reg == LAST_CNT) state_next = DONE;
            DONE: if (bus.out_ready) state_next = accept ? (fast ? DONE : CALC) : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration and result/flag registration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            func_reg    <= '0;
            tag_reg     <= '0;
            sa_reg      <= 1'b0;
            sb_reg      <= 1'b0;
            m_reg       <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            dst_reg     <= '0;
            out_tag_reg <= '0;
            ov_reg      <= 1'b0;
            zr_reg      <= 1'b0;
            neg_reg     <= 1'b0;
            dz_reg      <= 1'b0;
        end else if (accept) begin
            func_reg <= bus.func;
            tag_reg  <= bus.in_tag;
            sa_reg   <= in_sa;
            sb_reg   <= in_sb;
            cnt_reg  <= '0;
            hi_reg   <= '0;
            lo_reg   <= in_div ? a_mag : b_mag;
            m_reg    <= in_div ? b_mag : a_mag;
            if (fast) begin
                dst_reg     <= fast_dst;
                out_tag_reg <= bus.in_tag;
                ov_reg      <= 1'b1;
                dz_reg      <= div_zero;
                zr_reg      <= (fast_dst == '0);
                neg_reg     <= in_signed & fast_dst[WIDTH-1];
            end
        end else if (state_reg == CALC) begin
            hi_reg <= step_hi;
            lo_reg <= step_lo;
            if (cnt_reg == LAST_CNT) begin
                cnt_reg     <= '0;
                dst_reg     <= fin_dst;
                out_tag_reg <= tag_reg;
                ov_reg      <= fin_ov;
                dz_reg      <= 1'b0;
                zr_reg      <= (fin_dst == '0);
                neg_reg     <= f_signed & fin_dst[WIDTH-1];
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.dst       = dst_reg;
    assign bus.out_tag   = out_tag_reg;
    assign bus.ov        = ov_reg;
    assign bus.zr        = zr_reg;
    assign bus.neg       = neg_reg;
    assign bus.dz        = dz_reg;

endmodule

// File: tb/tb_alu_ext_seq.sv
// Bench for alu_ext_seq (WIDTH=32): directed cases, backpressure,
// back-to-back issue, reset mid-operation and randomized operations, all
// checked against an arithmetic reference model.
module tb_alu_ext_seq;
    import alu_ext_pkg::*;

    localparam int W  = 32;
    localparam int TW = 4;

    typedef struct packed {
        logic [W-1:0] dst;
        logic         ov;
        logic         zr;
        logic         neg;
        logic         dz;
        logic         fast;
    } res_t;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_ext_seq_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    alu_ext_seq #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic and the special-case rules
    function automatic res_t model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t               r;
        longint             sp;
        logic [63:0]        up;
        logic signed [W-1:0] q;
        r  = '0;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'b0, a} * {32'b0, b};
        case (f)
            3'd0: begin r.dst = sp[31:0]; r.ov = (sp > 64'sd2147483647) || (sp < -64'sd2147483648); end
            3'd1: begin r.dst = up[31:0]; r.ov = (up[63:32] != 0); end
            3'd2: r.dst = sp[63:32];
            3'd3: r.dst = up[63:32];
            default: begin
                if (b == 0) begin
                    r.dst = f[1] ? a : 32'hFFFF_FFFF;
                    r.ov = 1'b1; r.dz = 1'b1; r.fast = 1'b1;
                end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.dst = f[1] ? 32'h0 : 32'h8000_0000;
                    r.ov = 1'b1; r.fast = 1'b1;
                end else if (!f[0]) begin
                    q = f[1] ? ($signed(a) % $signed(b)) : ($signed(a) / $signed(b));
                    r.dst = q;
                end else begin
                    r.dst = f[1] ? (a % b) : (a / b);
                end
            end
        endcase
        r.zr  = (r.dst == 0);
        r.neg = !f[0] && r.dst[W-1];
        return r;
    endfunction

    // Present a request at the falling edge; it is accepted at the next rising edge
    task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] t, input bit rel, output res_t e);
        e = model(f, a, b);
        @(negedge clk);
        bus.func = f; bus.src1 = a; bus.src0 = b; bus.in_tag = t;
        bus.in_valid = 1'b1; bus.out_ready = rel;
        #1;
        chk("in_ready_at_issue", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.src1 = $urandom; bus.src0 = $urandom;
        bus.func = 3'($urandom_range(0, 7)); bus.in_tag = 4'($urandom);
        $display("[TB] issue func=%0d a=%08h b=%08h tag=%0d", f, a, b, t);
    endtask

    // Wait for the result (bounded), check it, and optionally hand it off
    task automatic wait_result(input res_t e, input logic [TW-1:0] t, input bit rel);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            if (lat < 8) bus.in_valid = 1'b1;   // must be ignored while busy
            else         bus.in_valid = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("latency", 64'(lat), e.fast ? 64'd1 : 64'd33);
        chk("out_valid", 64'(bus.out_valid), 64'd1);
        chk("dst", 64'(bus.dst), 64'(e.dst));
        chk("out_tag", 64'(bus.out_tag), 64'(t));
        chk("ov", 64'(bus.ov), 64'(e.ov));
        chk("zr", 64'(bus.zr), 64'(e.zr));
        chk("neg", 64'(bus.neg), 64'(e.neg));
        chk("dz", 64'(bus.dz), 64'(e.dz));
        chk("in_ready_done", 64'(bus.in_ready), 64'd0);
        $display("[TB] result dst=%08h tag=%0d ov=%b zr=%b neg=%b dz=%b lat=%0d",
                 bus.dst, bus.out_tag, bus.ov, bus.zr, bus.neg, bus.dz, lat);
        if (rel) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            chk("out_valid_drop", 64'(bus.out_valid), 64'd0);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] t);
        res_t e;
        issue(f, a, b, t, 1'b0, e);
        wait_result(e, t, 1'b1);
    endtask

    initial begin
        res_t        e;
        res_t        e2;
        int          stale;
        logic [2:0]  rf;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.func = '0;
        bus.src1 = '0; bus.src0 = '0; bus.in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_dst", 64'(bus.dst), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_flags", 64'({bus.ov, bus.zr, bus.neg, bus.dz}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(FUNC_MUL,   32'hFFFF_FFFD, 32'h0000_0007, 4'd1);
        run_op(FUNC_UMUL,  32'h0001_0000, 32'h0001_0000, 4'd2);
        run_op(FUNC_MULHU, 32'h0001_0000, 32'h0001_0000, 4'd3);
        run_op(FUNC_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4);
        run_op(FUNC_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 4'd5);
        run_op(FUNC_REM,   32'hFFFF_FFF9, 32'h0000_0002, 4'd6);
        run_op(FUNC_UREM,  32'h0000_000A, 32'h0000_0003, 4'd7);
        run_op(FUNC_UDIV,  32'h0000_0005, 32'h0000_0000, 4'd8);
        run_op(FUNC_UREM,  32'h0000_0005, 32'h0000_0000, 4'd9);
        run_op(FUNC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 4'd10);
        run_op(FUNC_REM,   32'h8000_0000, 32'hFFFF_FFFF, 4'd11);
        run_op(FUNC_MUL,   32'h8000_0000, 32'h8000_0000, 4'd12);

        // Backpressure: result held 10 clocks, then handed off with a new accept
        issue(FUNC_DIV, 32'h1234_5678, 32'hFFFF_FF00, 4'd3, 1'b0, e);
        wait_result(e, 4'd3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_dst", 64'(bus.dst), 64'(e.dst));
            chk("bp_tag", 64'(bus.out_tag), 64'd3);
            chk("bp_flags", 64'({bus.ov, bus.zr, bus.neg, bus.dz}), 64'({e.ov, e.zr, e.neg, e.dz}));
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        issue(FUNC_MULH, 32'h7FFF_FFFF, 32'h8000_0001, 4'd5, 1'b1, e2);
        chk("b2b_busy", 64'(bus.out_valid), 64'd0);
        wait_result(e2, 4'd5, 1'b1);

        // Reset during the iterative phase
        issue(FUNC_UMUL, 32'hDEAD_BEEF, 32'h0000_1234, 4'd6, 1'b0, e);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) stale++;
        end
        chk("no_stale_result", 64'(stale), 64'd0);
        run_op(FUNC_UMUL, 32'hDEAD_BEEF, 32'h0000_1234, 4'd7);

        // Randomized operations with biased special operands
        for (int i = 0; i < 48; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 40)) - 32'd20; rb = 32'($urandom_range(0, 10)) - 32'd5; end
                default: ;
            endcase
            run_op(rf, ra, rb, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ext_seq.md
Name: alu_ext_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle extended ALU. It performs signed and unsigned integer multiply (low or high half) and divide/remainder on WIDTH-bit operands using an iterative radix-2 datapath. Operand input and result output each use a valid/ready handshake, with a tag carried through for the issuing pipeline. It sits beside the main ALU in EX and writes back to the EX/DM boundary when the result is accepted.

Parameters:
WIDTH, 32, operand and result width; must be >= 4.
TAG_W, 4, width of the opaque tag passed from request to result.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
func  in  3  operation select (encodings under Behaviour)
src1  in  WIDTH  operand A (multiplicand / dividend)
src0  in  WIDTH  operand B (multiplier / divisor)
in_tag  in  TAG_W  request tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
dst  out  WIDTH  result
out_tag  out  TAG_W  tag of the completed request
ov  out  1  overflow flag
zr  out  1  result == 0
neg  out  1  result MSB for signed ops; 0 for unsigned ops
dz  out  1  divide by zero

Behaviour:
- func encodings: 000 MUL (signed, low half); 001 UMUL (low); 010 MULH (signed×signed, high); 011 MULHU (high); 100 DIV; 101 UDIV; 110 REM; 111 UREM.
- Reset (async, rst_n=0): state IDLE. in_ready=1. out_valid=0. dst=0, out_tag=0, ov=zr=neg=dz=0. Iteration counter=0.
- FSM states and transitions:
  - IDLE: in_ready=1. Accept on in_valid&in_ready. Go to CALC, or to DONE on the fast path.
  - CALC: exactly WIDTH iterations, one per clock. Counter counts 0..WIDTH-1. After the last iteration the result and flags are registered, then the state goes to DONE.
  - DONE: out_valid=1; dst, out_tag and flags held stable until out_ready=1. On out_ready: go to IDLE, or accept a new request in the same cycle if in_valid=1 (in_ready = IDLE | (DONE & out_ready)).
- Latency:
  - Normal: out_valid rises WIDTH+1 clocks after the accept edge.
  - Fast path: out_valid rises 1 clock after the accept edge.
  - Throughput: one op per WIDTH+1 clocks with back-to-back accept.
- Operands and tag are latched on accept. Input changes during CALC/DONE have no effect.
- Multiply:
  - Signed ops take magnitudes first. Shift-add over WIDTH steps produces a 2*WIDTH-bit product, which is negated if the operand signs differ.
  - MUL/UMUL return the low half. MULH/MULHU return the high half.
  - ov (MUL) = 1 when the full signed product is not representable in WIDTH bits.
  - ov (UMUL) = 1 when the high half is non-zero.
  - ov = 0 for MULH/MULHU.
- Divide:
  - Restoring division on magnitudes, WIDTH steps.
  - Quotient truncates toward zero; its sign is sign(A) xor sign(B).
  - Remainder takes the sign of the dividend.
- Fast path, decided at accept:
  - Divisor 0: quotient = all ones; remainder = src1; dz=1, ov=1.
  - Signed MIN / -1: DIV = MIN, REM = 0, ov=1, dz=0.
- Flags:
  - zr = (dst == 0) for all ops.
  - neg = dst[WIDTH-1] for MUL, MULH, DIV, REM; neg = 0 for UMUL, MULHU, UDIV, UREM.
  - Flags are registered together with dst.
- Reset mid-operation: the operation is aborted, no result is produced, and the block returns to IDLE.
- out_ready is ignored while not in DONE. in_valid is ignored while in CALC.

Decomposition:
- Shared package alu_ext_pkg holds:
  - func encoding constants (MUL..UREM);
  - FSM state encoding (IDLE, CALC, DONE);
  - the divide-by-zero result constant (all ones).
- One natural sub-module: abs_neg, a combinational conditional two's-complement negate of width N. It is used for operand magnitudes and for result sign correction.

Test Plan:
1. WIDTH=32, MUL src1=FFFFFFFD, src0=00000007 -> dst=FFFFFFEB, neg=1, ov=0, zr=0; out_valid exactly 33 clocks after accept.
2. UMUL 00010000×00010000 -> dst=00000000, zr=1, ov=1. Then MULHU with the same operands -> dst=00000001, ov=0. MULH FFFFFFFF×FFFFFFFF -> 00000000.
3. DIV FFFFFFF9 / 00000002 -> FFFFFFFD (-3). REM with the same operands -> FFFFFFFF (-1), neg=1. UREM 0000000A / 00000003 -> 00000001.
4. UDIV 00000005 / 00000000 -> FFFFFFFF, dz=1, ov=1, out_valid 1 clock after accept. UREM 5/0 -> 00000005. DIV 80000000 / FFFFFFFF -> 80000000, ov=1, dz=0; REM -> 0.
5. Backpressure and back-to-back:
  - Hold out_ready=0 for 10 clocks in DONE -> dst, out_tag and flags stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 (tag=5) in the same cycle -> new op accepted that edge; its result arrives with out_tag=5.
6. Reset mid-CALC: rst_n low 3 clocks after accept -> out_valid=0 and in_ready=1 immediately. No stale result appears. The next op completes correctly.
